// File: rtl/neocore_pkg.sv
// rtl/neocore_pkg.sv - shared types and constants for the memory port arbiter
package neocore_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_DM = 2'd2
  } arb_state_e;

  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch (IF) and data (DM)
//
// Purpose: one outstanding memory transaction at a time. DM wins by default;
// after STARVE_MAX consecutive DM grants with IF waiting, IF is forced to win.
// Optional watchdog compiled in with `define MEM_ARB_TIMEOUT_EN.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata   fetch accept, response pulse and data
//   dm_req/dm_we/dm_size/
//   dm_addr/dm_wdata            data request payload (held until dm_gnt)
//   dm_gnt/dm_rvalid/dm_rdata   data accept, response pulse and data
//   mem_req/mem_we/mem_size/
//   mem_addr/mem_wdata          request to memory, driven from the winner
//   mem_ready                   memory accepts mem_req this cycle
//   mem_rvalid/mem_rdata        response for the outstanding request
//   arb_err                     sticky watchdog timeout flag
module mem_port_arbiter
  import neocore_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int STARVE_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [SW-1:0]     starve_cnt;
  logic              dm_wins;
  logic              if_wins;
  logic              resp_done;
  logic [DATA_W-1:0] resp_data;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LIM = WW'(TIMEOUT_CYCLES);

  logic [WW-1:0] wd_cnt;
  logic          arb_err_q;
  logic          timeout;

  assign timeout = (state_q != ARB_IDLE) && (wd_cnt == WD_LIM);
  assign arb_err = arb_err_q;

  // Count held at 0 while idle, so every BUSY period starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      arb_err_q <= 1'b0;
    end else if (state_q == ARB_IDLE) begin
      wd_cnt <= '0;
    end else if (mem_rvalid) begin
      wd_cnt <= '0;
    end else if (timeout) begin
      wd_cnt    <= '0;
      arb_err_q <= 1'b1;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign arb_err = 1'b0;
`endif

  always_comb begin
    // A real response beats a coincident timeout; a timeout returns zero data.
    resp_done = mem_rvalid;
    resp_data = mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
    if (timeout && !mem_rvalid) begin
      resp_done = 1'b1;
      resp_data = '0;
    end
`endif
  end

  assign dm_wins = dm_req && !(if_req && (starve_cnt == STARVE_LIM));
  assign if_wins = if_req && !dm_wins;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  // Outputs are gated by rst so the reset cycle shows all-zero outputs and
  // a response arriving during reset is dropped.
  always_comb begin
    state_d   = state_q;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_size  = 2'd0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ARB_IDLE: begin
        if (!rst && dm_wins) begin
          mem_req   = 1'b1;
          mem_we    = dm_we;
          mem_size  = dm_size;
          mem_addr  = dm_addr;
          mem_wdata = dm_wdata;
          dm_gnt    = mem_ready;
          if (mem_ready) state_d = ARB_BUSY_DM;
        end else if (!rst && if_wins) begin
          mem_req  = 1'b1;
          mem_size = MEM_SIZE_WORD;
          mem_addr = if_addr;
          if_gnt   = mem_ready;
          if (mem_ready) state_d = ARB_BUSY_IF;
        end
      end
      ARB_BUSY_IF: begin
        if (!rst && resp_done) begin
          if_rvalid = 1'b1;
          if_rdata  = resp_data;
          state_d   = ARB_IDLE;
        end
      end
      ARB_BUSY_DM: begin
        if (!rst && resp_done) begin
          dm_rvalid = 1'b1;
          dm_rdata  = resp_data;
          state_d   = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Counts consecutive DM grants that left IF waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (dm_gnt && if_req) begin
      if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
    end else if (state_q == ARB_IDLE && !if_req) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [63:0] if_rdata;
  logic        dm_req, dm_we;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [63:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready, mem_rvalid;
  logic [63:0] mem_rdata;
  logic        arb_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(64), .STARVE_MAX(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks run 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [5:0] exp_if_seq;
    int         lat;

    rst = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_size = 0;
    dm_addr = '0; dm_wdata = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    tick(); tick();
    // Reset state: requests during reset must not reach memory
    if_req = 1; mem_ready = 1; settle();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_if_gnt", if_gnt, 1'b0);
    check("rst_arb_err", arb_err, 1'b0);
    if_req = 0; mem_ready = 0;
    tick(); rst = 1'b0;
    tick();

    // 1. Fetch only
    if_req = 1; if_addr = 32'h100; mem_ready = 1; settle();
    check("t1_if_gnt", if_gnt, 1'b1);
    check("t1_mem_req", mem_req, 1'b1);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_mem_we", mem_we, 1'b0);
    check("t1_mem_size", mem_size, 2'd2);
    tick(); if_req = 0; settle();
    check("t1_busy_mem_req", mem_req, 1'b0);
    tick();
    tick(); mem_rvalid = 1; mem_rdata = 64'hDEAD; settle();
    check("t1_if_rvalid", if_rvalid, 1'b1);
    check("t1_if_rdata", if_rdata, 64'hDEAD);
    check("t1_dm_rvalid", dm_rvalid, 1'b0);
    tick(); mem_rvalid = 0; settle();
    check("t1_rvalid_pulse", if_rvalid, 1'b0);

    // 2. Simultaneous IF and DM store
    if_req = 1; if_addr = 32'h300;
    dm_req = 1; dm_we = 1; dm_size = 2'd1; dm_addr = 32'h200; dm_wdata = 64'h55AA; settle();
    check("t2_dm_gnt", dm_gnt, 1'b1);
    check("t2_if_gnt_wait", if_gnt, 1'b0);
    check("t2_mem_we", mem_we, 1'b1);
    check("t2_mem_size", mem_size, 2'd1);
    check("t2_mem_addr", mem_addr, 32'h200);
    check("t2_mem_wdata", mem_wdata, 64'h55AA);
    tick(); dm_req = 0; dm_we = 0; settle();
    check("t2_busy_if_gnt", if_gnt, 1'b0);
    tick(); mem_rvalid = 1; mem_rdata = 64'h0; settle();
    check("t2_dm_rvalid", dm_rvalid, 1'b1);
    check("t2_if_gnt_on_rvalid", if_gnt, 1'b0);
    tick(); mem_rvalid = 0; settle();
    check("t2_if_gnt_after", if_gnt, 1'b1);
    check("t2_if_addr", mem_addr, 32'h300);
    check("t2_if_size", mem_size, 2'd2);
    tick(); if_req = 0; mem_rvalid = 1; mem_rdata = 64'h77; settle();
    check("t2_if_rvalid", if_rvalid, 1'b1);
    tick(); mem_rvalid = 0;
    tick();

    // 3. Starvation guard, STARVE_MAX = 4: D D D D I D
    exp_if_seq = 6'b010000;
    if_req = 1; if_addr = 32'h400; dm_req = 1; dm_we = 0; dm_size = 2'd2; dm_addr = 32'h500;
    for (int n = 0; n < 6; n++) begin
      settle();
      check($sformatf("t3_if_gnt_%0d", n), if_gnt, exp_if_seq[n]);
      check($sformatf("t3_dm_gnt_%0d", n), dm_gnt, !exp_if_seq[n]);
      tick(); mem_rvalid = 1;
      tick(); mem_rvalid = 0;
    end
    if_req = 0; dm_req = 0;
    tick();

    // 4. mem_ready low in IDLE: request held, no grant
    mem_ready = 0; dm_req = 1; dm_we = 0; dm_size = 2'd2; dm_addr = 32'h600;
    for (int n = 0; n < 5; n++) begin
      settle();
      check($sformatf("t4_no_gnt_%0d", n), dm_gnt, 1'b0);
      check($sformatf("t4_mem_req_%0d", n), mem_req, 1'b1);
      check($sformatf("t4_addr_%0d", n), mem_addr, 32'h600);
      tick();
    end
    mem_ready = 1; settle();
    check("t4_gnt_on_ready", dm_gnt, 1'b1);
    tick(); dm_req = 0;

    // 5. Reset while BUSY_DM, response arrives during and after reset
    tick();
    rst = 1; mem_rvalid = 1; mem_rdata = 64'hBEEF; settle();
    check("t5_dm_rvalid_in_rst", dm_rvalid, 1'b0);
    tick(); rst = 0; settle();
    check("t5_dm_rvalid_stale", dm_rvalid, 1'b0);
    check("t5_if_rvalid_stale", if_rvalid, 1'b0);
    check("t5_dm_rdata", dm_rdata, 64'h0);
    check("t5_mem_req", mem_req, 1'b0);
    tick(); mem_rvalid = 0;
    // IDLE is confirmed by an immediate grant
    if_req = 1; if_addr = 32'h700; settle();
    check("t5_idle_gnt", if_gnt, 1'b1);
    tick(); if_req = 0; mem_rvalid = 1; settle();
    check("t5_if_rvalid", if_rvalid, 1'b1);
    tick(); mem_rvalid = 0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // 6. Watchdog: load with no response, TIMEOUT_CYCLES = 8
    dm_req = 1; dm_we = 0; dm_addr = 32'h800; mem_rdata = 64'h1234; settle();
    check("t6_dm_gnt", dm_gnt, 1'b1);
    tick(); dm_req = 0;
    lat = 0;
    for (int n = 1; n < 20; n++) begin
      settle();
      if (dm_rvalid && lat == 0) begin
        lat = n;
        check("t6_dm_rdata", dm_rdata, 64'h0);
      end
      tick();
    end
    check("t6_latency", lat, 9);
    check("t6_arb_err", arb_err, 1'b1);
    rst = 1; tick(); rst = 0; settle();
    check("t6_arb_err_clr", arb_err, 1'b0);
`else
    lat = 0;
    check("arb_err_tied", arb_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
